led_pattern_gen: RTL

- Parametrised successor to the board-level counter blinker.
- Drives NUM_CH output channels (LEDs or IO pins) from one of four runtime-selectable patterns: binary count, bouncing scan, PWM breathe, and static.
- A programmable prescaler sets the pattern step rate, and a valid/ready config port switches modes.
- Sits directly behind the top-level clock buffer and feeds the LED/IO output registers.

---
 rtl/led_pattern_gen_if.sv | 9 +
 rtl/led_pattern_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen_if.sv
// Mode-change request channel of led_pattern_gen: valid/ready handshake carrying the requested pattern mode.
interface led_pattern_gen_if;
    logic       CFG_VALID;
    logic [1:0] CFG_MODE;
    logic       CFG_READY;

    modport master (output CFG_VALID, output CFG_MODE, input CFG_READY);
    modport slave  (input CFG_VALID, input CFG_MODE, output CFG_READY);
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED/IO pattern generator: binary count, bouncing scan, PWM breathe and static patterns
// stepped by a programmable prescaler, with a valid/ready mode-change port.
module led_pattern_gen #(
    parameter int NUM_CH       = 4,
    parameter int PRESCALE_DIV = 200000,
    parameter int PWM_BITS     = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ENABLE,
    input  logic [NUM_CH-1:0] PATTERN,
    output logic [NUM_CH-1:0] CH,
    output logic              TICK,
    led_pattern_gen_if.slave  cfg
);

    localparam int PRESC_W = $clog2(PRESCALE_DIV);
    localparam int POS_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE_DIV - 1);
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(NUM_CH - 1);
    localparam logic [POS_W-1:0]   POS_PREV   = POS_W'((NUM_CH > 1) ? (NUM_CH - 2) : 0);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};

    localparam logic [1:0] MODE_COUNT   = 2'd0;
    localparam logic [1:0] MODE_SCAN    = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_STATIC  = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [1:0]          mode_r;
    logic                ready_r;
    logic                tick_r;
    logic [PRESC_W-1:0]  presc_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [NUM_CH-1:0]   step_r;
    logic [POS_W-1:0]    pos_r;
    logic                dir_r;
    logic [PWM_BITS-1:0] duty_r;
    logic                duty_dir_r;
    logic [NUM_CH-1:0]   ch_r;

    logic                accept_s;
    logic                presc_wrap_s;
    logic                advance_s;
    logic [POS_W-1:0]    pos_nxt_s;
    logic                dir_nxt_s;
    logic [PWM_BITS-1:0] duty_nxt_s;
    logic                duty_dir_nxt_s;
    logic [NUM_CH-1:0]   onehot_s;
    logic [NUM_CH-1:0]   ch_nxt_s;

    // A pattern step is taken in the cycle TICK is high; a simultaneous accept discards it.
    assign accept_s     = cfg.CFG_VALID & ready_r;
    assign presc_wrap_s = (presc_r == PRESC_LAST);
    assign advance_s    = tick_r & ENABLE & ~accept_s;

    // Bouncing scan: reverse at either end without dwelling on the endpoint.
    always_comb begin
        pos_nxt_s = pos_r;
        dir_nxt_s = dir_r;
        if (NUM_CH == 1) begin
            pos_nxt_s = '0;
            dir_nxt_s = DIR_UP;
        end else if (dir_r == DIR_UP) begin
            if (pos_r == POS_LAST) begin
                pos_nxt_s = POS_PREV;
                dir_nxt_s = DIR_DOWN;
            end else begin
                pos_nxt_s = pos_r + POS_W'(1);
            end
        end else begin
            if (pos_r == '0) begin
                pos_nxt_s = POS_W'(1);
                dir_nxt_s = DIR_UP;
            end else begin
                pos_nxt_s = pos_r - POS_W'(1);
            end
        end
    end

    // Triangle ramp of the breathe duty cycle.
    always_comb begin
        duty_nxt_s     = duty_r;
        duty_dir_nxt_s = duty_dir_r;
        if (duty_dir_r == DIR_UP) begin
            if (duty_r == DUTY_MAX) begin
                duty_nxt_s     = DUTY_MAX - PWM_BITS'(1);
                duty_dir_nxt_s = DIR_DOWN;
            end else begin
                duty_nxt_s = duty_r + PWM_BITS'(1);
            end
        end else begin
            if (duty_r == '0) begin
                duty_nxt_s     = PWM_BITS'(1);
                duty_dir_nxt_s = DIR_UP;
            end else begin
                duty_nxt_s = duty_r - PWM_BITS'(1);
            end
        end
    end

    // One-hot decode of the scan position.
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            onehot_s[i] = (pos_r == POS_W'(i));
        end
    end

    // Channel value selected by the current mode.
    always_comb begin
        ch_nxt_s = '0;
        if (!ENABLE) begin
            ch_nxt_s = '0;
        end else begin
            case (mode_r)
                MODE_COUNT:   ch_nxt_s = step_r;
                MODE_SCAN:    ch_nxt_s = onehot_s;
                MODE_BREATHE: ch_nxt_s = {NUM_CH{pwm_cnt_r < duty_r}};
                MODE_STATIC:  ch_nxt_s = PATTERN;
                default:      ch_nxt_s = '0;
            endcase
        end
    end

    // Handshake, mode, prescaler, tick and PWM counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_r    <= MODE_COUNT;
            ready_r   <= 1'b1;
            tick_r    <= 1'b0;
            presc_r   <= '0;
            pwm_cnt_r <= '0;
        end else begin
            ready_r <= ~accept_s;
            if (accept_s) begin
                mode_r    <= cfg.CFG_MODE;
                tick_r    <= 1'b0;
                presc_r   <= '0;
                pwm_cnt_r <= '0;
            end else if (ENABLE) begin
                tick_r    <= presc_wrap_s;
                presc_r   <= presc_wrap_s ? '0 : (presc_r + PRESC_W'(1));
                pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            end else begin
                tick_r <= 1'b0;
            end
        end
    end

    // Per-mode pattern state, advanced once per step.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step_r     <= '0;
            pos_r      <= '0;
            dir_r      <= DIR_UP;
            duty_r     <= '0;
            duty_dir_r <= DIR_UP;
        end else if (accept_s) begin
            step_r     <= '0;
            pos_r      <= '0;
            dir_r      <= DIR_UP;
            duty_r     <= '0;
            duty_dir_r <= DIR_UP;
        end else if (advance_s) begin
            case (mode_r)
                MODE_COUNT: step_r <= step_r + NUM_CH'(1);
                MODE_SCAN: begin
                    pos_r <= pos_nxt_s;
                    dir_r <= dir_nxt_s;
                end
                MODE_BREATHE: begin
                    duty_r     <= duty_nxt_s;
                    duty_dir_r <= duty_dir_nxt_s;
                end
                default: step_r <= step_r;
            endcase
        end else begin
            step_r <= step_r;
        end
    end

    // Registered channel outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ch_r <= '0;
        end else begin
            ch_r <= ch_nxt_s;
        end
    end

    assign CH            = ch_r;
    assign TICK          = tick_r;
    assign cfg.CFG_READY = ready_r;

endmodule
